vector_ls_sequencer: RTL and testbench

//  Multi-cycle sequencer for vector loads/stores (VLW, VSW, VLWO, VSWO) on the SIMT datapath.

---
 rtl/vector_ls_sequencer_pkg.sv | 24 ++
 rtl/vector_ls_sequencer_if.sv | 44 ++++
 rtl/vector_ls_sequencer_lane_prio_enc.sv | 29 ++
 rtl/vector_ls_sequencer.sv | 111 +++++++++++
 tb/tb_vector_ls_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_ls_sequencer_pkg.sv
// Shared types and helpers for the vector load/store sequencer.
// Contents:
//   VLS_THREADS / VLS_WORD_W  default lane count and data/address width
//   vls_state_t               sequencer FSM states
//   thread_mask_t             one active bit per lane
//   lane_w()                  lane index width, never below 1
package vector_ls_sequencer_pkg;

  localparam int VLS_THREADS = 4;
  localparam int VLS_WORD_W  = 32;

  typedef enum logic [1:0] {
    VLS_IDLE   = 2'd0,
    VLS_ACCESS = 2'd1,
    VLS_DONE   = 2'd2
  } vls_state_t;

  typedef logic [VLS_THREADS-1:0] thread_mask_t;

  function automatic int lane_w(input int threads);
    return (threads > 1) ? $clog2(threads) : 1;
  endfunction

endpackage

// File: rtl/vector_ls_sequencer_if.sv
// Bus bundle between the control/datapath side and the sequencer.
// master: issue side (start, is_store, use_mask, mask, lane operands) plus the
//         dcache response (dhit, dmemload); observes requests, writeback,
//         stall and done.
// slave:  the sequencer itself.
interface vector_ls_sequencer_if
  import vector_ls_sequencer_pkg::*;
#(
  parameter int THREADS = VLS_THREADS,
  parameter int WORD_W  = VLS_WORD_W
);
  localparam int LANE_W = lane_w(THREADS);

  logic                      start;
  logic                      is_store;
  logic                      use_mask;
  logic [THREADS-1:0]        mask;
  logic [THREADS*WORD_W-1:0] lane_addr;
  logic [THREADS*WORD_W-1:0] lane_wdata;
  logic                      dhit;
  logic [WORD_W-1:0]         dmemload;
  logic                      dmemREN;
  logic                      dmemWEN;
  logic [WORD_W-1:0]         dmemaddr;
  logic [WORD_W-1:0]         dmemstore;
  logic                      vreg_wen;
  logic [LANE_W-1:0]         vreg_lane;
  logic [WORD_W-1:0]         vreg_wdata;
  logic                      stall;
  logic                      done;

  modport master (
    output start, is_store, use_mask, mask, lane_addr, lane_wdata, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, vreg_wen, vreg_lane, vreg_wdata,
           stall, done
  );

  modport slave (
    input  start, is_store, use_mask, mask, lane_addr, lane_wdata, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, vreg_wen, vreg_lane, vreg_wdata,
           stall, done
  );

endinterface

// File: rtl/vector_ls_sequencer_lane_prio_enc.sv
// Lowest-set-bit priority encoder over the pending lane mask.
// Ports:
//   i_pending  lanes still waiting for their memory transaction
//   o_lane     index of the lowest pending lane (0 when none)
//   o_any      at least one lane pending
module lane_prio_enc
  import vector_ls_sequencer_pkg::*;
#(
  parameter int THREADS = VLS_THREADS,
  parameter int LANE_W  = lane_w(THREADS)
) (
  input  logic [THREADS-1:0] i_pending,
  output logic [LANE_W-1:0]  o_lane,
  output logic               o_any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_lane = '0;
    o_any  = 1'b0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (i_pending[i]) begin
        o_lane = LANE_W'(i);
        o_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_ls_sequencer.sv
// Serialises one vector load/store into one dcache transaction per active lane.
// Ports:
//   CLK  clock, all state on the rising edge
//   RST  asynchronous active-high reset
//   bus  slave side of vector_ls_sequencer_if (issue, dcache, writeback, stall/done)
//
// state      | meaning
// VLS_IDLE   | waiting for start; operands and pending mask captured on start
// VLS_ACCESS | one request per cycle for the lowest pending lane until all complete
// VLS_DONE   | one-cycle done pulse, pipeline released
module vector_ls_sequencer
  import vector_ls_sequencer_pkg::*;
#(
  parameter int THREADS = VLS_THREADS,
  parameter int WORD_W  = VLS_WORD_W
) (
  input logic                  CLK,
  input logic                  RST,
  vector_ls_sequencer_if.slave bus
);

  localparam int LANE_W = lane_w(THREADS);

  vls_state_t                r_state;
  vls_state_t                w_state_nxt;
  logic [THREADS-1:0]        r_pending;
  logic                      r_is_store;
  logic [THREADS*WORD_W-1:0] r_addr;
  logic [THREADS*WORD_W-1:0] r_wdata;

  logic [THREADS-1:0]        w_start_pending;
  logic [THREADS-1:0]        w_lane_clr;
  logic [LANE_W-1:0]         w_lane;
  logic                      w_any;

  lane_prio_enc #(.THREADS(THREADS), .LANE_W(LANE_W)) u_prio (
    .i_pending (r_pending),
    .o_lane    (w_lane),
    .o_any     (w_any)
  );

  assign w_start_pending = bus.use_mask ? bus.mask : '1;
  assign w_lane_clr      = r_pending & ~(THREADS'(1) << w_lane);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= VLS_IDLE;
      r_pending  <= '0;
      r_is_store <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == VLS_IDLE && bus.start) begin
        r_pending  <= w_start_pending;
        r_is_store <= bus.is_store;
        r_addr     <= bus.lane_addr;
        r_wdata    <= bus.lane_wdata;
      end else if (r_state == VLS_ACCESS && bus.dhit) begin
        r_pending <= w_lane_clr;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.dmemREN    = 1'b0;
    bus.dmemWEN    = 1'b0;
    bus.dmemaddr   = '0;
    bus.dmemstore  = '0;
    bus.vreg_wen   = 1'b0;
    bus.vreg_lane  = '0;
    bus.vreg_wdata = '0;
    bus.stall      = 1'b0;
    bus.done       = 1'b0;
    case (r_state)
      VLS_IDLE: begin
        // Gated with RST so every output reads 0 while reset is held.
        bus.stall = bus.start & ~RST;
        if (bus.start) begin
          w_state_nxt = (w_start_pending == '0) ? VLS_DONE : VLS_ACCESS;
        end
      end
      VLS_ACCESS: begin
        bus.stall = 1'b1;
        if (w_any) begin
          bus.dmemREN   = ~r_is_store;
          bus.dmemWEN   = r_is_store;
          bus.dmemaddr  = r_addr[int'(w_lane)*WORD_W +: WORD_W];
          bus.dmemstore = r_wdata[int'(w_lane)*WORD_W +: WORD_W];
          if (bus.dhit) begin
            if (!r_is_store) begin
              bus.vreg_wen   = 1'b1;
              bus.vreg_lane  = w_lane;
              bus.vreg_wdata = bus.dmemload;
            end
            if (w_lane_clr == '0) w_state_nxt = VLS_DONE;
          end
        end else begin
          w_state_nxt = VLS_DONE;
        end
      end
      VLS_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = VLS_IDLE;
      end
      default: w_state_nxt = VLS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_ls_sequencer.sv
// Scoreboard bench for vector_ls_sequencer (THREADS=4, WORD_W=32).
module tb_vector_ls_sequencer;
  import vector_ls_sequencer_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  vector_ls_sequencer_if #(.THREADS(4), .WORD_W(32)) bus ();

  vector_ls_sequencer #(.THREADS(4), .WORD_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {logic we; logic [31:0] addr; logic [31:0] data; int hold;} mem_exp_t;
  typedef struct {logic [1:0] lane; logic [31:0] data;} wb_exp_t;
  typedef struct {int cyc; int stalls;} done_exp_t;

  mem_exp_t  q_mem[$];
  wb_exp_t   q_wb[$];
  done_exp_t q_done[$];

  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  logic [31:0] hold_addr = '0;
  int          hold_left = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: word at 0x..0, 0x..4, 0x..8, 0x..C returns A0, A1, A2, A3.
  assign bus.dmemload = 32'hA0 + {28'd0, bus.dmemaddr[5:2]};

  // dcache responder: withholds dhit for hold_left cycles on hold_addr.
  always @(negedge CLK) begin
    if ((bus.dmemREN || bus.dmemWEN) && hold_left > 0 && bus.dmemaddr == hold_addr) begin
      bus.dhit = 1'b0;
      hold_left--;
    end else begin
      bus.dhit = 1'b1;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ren"},   {31'd0, bus.dmemREN}, 32'd0);
    chk({tag, "_wen"},   {31'd0, bus.dmemWEN}, 32'd0);
    chk({tag, "_addr"},  bus.dmemaddr, 32'd0);
    chk({tag, "_store"}, bus.dmemstore, 32'd0);
    chk({tag, "_vwen"},  {31'd0, bus.vreg_wen}, 32'd0);
    chk({tag, "_vlane"}, {30'd0, bus.vreg_lane}, 32'd0);
    chk({tag, "_vdata"}, bus.vreg_wdata, 32'd0);
    chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    chk({tag, "_done"},  {31'd0, bus.done}, 32'd0);
  endtask

  // Monitor: pops expectations whenever the DUT completes a transaction,
  // writes back a lane or pulses done.
  initial begin : monitor
    bit          pend;
    logic [31:0] paddr;
    int          hcnt;
    int          stalls;
    mem_exp_t    m;
    wb_exp_t     w;
    done_exp_t   d;
    pend = 1'b0; paddr = '0; hcnt = 0; stalls = 0;
    forever begin
      @(negedge CLK);
      #2;
      if (!chk_en) begin
        pend = 1'b0; hcnt = 0; stalls = 0;
      end else begin
        if (bus.stall) stalls++;
        if (bus.dmemREN || bus.dmemWEN) begin
          if (pend) begin
            chk("held_addr", bus.dmemaddr, paddr);
            hcnt++;
          end else begin
            hcnt = 1;
          end
          if (bus.dhit) begin
            pend = 1'b0;
            if (q_mem.size() == 0) begin
              n_chk++; n_bad++;
              $display("FAIL unexpected_mem: addr %h wen %b, none expected", bus.dmemaddr, bus.dmemWEN);
            end else begin
              m = q_mem.pop_front();
              chk("mem_wen", {31'd0, bus.dmemWEN}, {31'd0, m.we});
              chk("mem_ren", {31'd0, bus.dmemREN}, {31'd0, ~m.we});
              chk("mem_addr", bus.dmemaddr, m.addr);
              if (m.we) chk("mem_store", bus.dmemstore, m.data);
              chk("mem_hold", hcnt, m.hold);
            end
          end else begin
            pend  = 1'b1;
            paddr = bus.dmemaddr;
          end
        end else begin
          pend = 1'b0;
        end
        if (bus.vreg_wen) begin
          if (q_wb.size() == 0) begin
            n_chk++; n_bad++;
            $display("FAIL unexpected_wb: lane %0d data %h, none expected", bus.vreg_lane, bus.vreg_wdata);
          end else begin
            w = q_wb.pop_front();
            chk("wb_lane", {30'd0, bus.vreg_lane}, {30'd0, w.lane});
            chk("wb_data", bus.vreg_wdata, w.data);
          end
        end
        if (bus.done) begin
          if (q_done.size() == 0) begin
            n_chk++; n_bad++;
            $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
          end else begin
            d = q_done.pop_front();
            chk("done_cycle", cyc, d.cyc);
            chk("stall_cycles", stalls, d.stalls);
          end
          stalls = 0;
        end
      end
    end
  end

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] data, input int hold);
    q_mem.push_back('{we, addr, data, hold});
  endtask

  task automatic push_wb(input logic [1:0] lane, input logic [31:0] data);
    q_wb.push_back('{lane, data});
  endtask

  // Drives a one-cycle start; lat/stl are the expected done offset and stall count.
  task automatic issue(input logic st, input logic um, input logic [3:0] mk,
                       input logic [31:0] base, input logic [127:0] wd,
                       input int lat, input int stl);
    int t0;
    @(posedge CLK); #1;
    t0 = cyc;
    if (chk_en) q_done.push_back('{t0 + lat, stl});
    bus.is_store = st;
    bus.use_mask = um;
    bus.mask     = mk;
    for (int i = 0; i < 4; i++) bus.lane_addr[i*32 +: 32] = base + 32'(4 * i);
    bus.lane_wdata = wd;
    bus.start      = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (q_done.size() != 0 && k < 60) begin
      @(posedge CLK);
      k++;
    end
    if (q_done.size() != 0) begin
      n_chk++; n_bad++;
      $display("FAIL %s_timeout: done not seen, %0d outstanding", name, q_done.size());
      q_done.delete();
    end
    @(posedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.is_store = 1'b0; bus.use_mask = 1'b0; bus.mask = '0;
    bus.lane_addr = '0; bus.lane_wdata = '0;
    #3;
    chk_all_zero("por");
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // 1: reset asserted mid-ACCESS with dhit withheld.
    chk_en    = 1'b0;
    hold_addr = 32'h100;
    hold_left = 1000;
    issue(1'b0, 1'b0, 4'hF, 32'h100, '0, 0, 0);
    #2;
    chk("pre_rst_ren", {31'd0, bus.dmemREN}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk_all_zero("async_rst");
    hold_left = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    chk_all_zero("post_rst");
    chk_en = 1'b1;

    // 2: unmasked VLW.
    for (int i = 0; i < 4; i++) begin
      push_mem(1'b0, 32'h100 + 32'(4 * i), '0, 1);
      push_wb(2'(i), 32'hA0 + 32'(i));
    end
    issue(1'b0, 1'b0, 4'h0, 32'h100, '0, 5, 5);
    wait_idle("vlw");

    // 3: masked VSW, lanes 1 and 3.
    push_mem(1'b1, 32'h204, 32'h22, 1);
    push_mem(1'b1, 32'h20C, 32'h44, 1);
    issue(1'b1, 1'b1, 4'b1010, 32'h200, 128'h00000044_00000033_00000022_00000011, 3, 3);
    wait_idle("vsw_mask");

    // 4: masked op with an empty mask.
    issue(1'b0, 1'b1, 4'b0000, 32'h500, '0, 1, 1);
    wait_idle("mask0");

    // 5: dhit withheld three cycles on lane 2 of a load.
    hold_addr = 32'h308;
    hold_left = 3;
    push_mem(1'b0, 32'h300, '0, 1);
    push_mem(1'b0, 32'h304, '0, 1);
    push_mem(1'b0, 32'h308, '0, 4);
    push_mem(1'b0, 32'h30C, '0, 1);
    for (int i = 0; i < 4; i++) push_wb(2'(i), 32'hA0 + 32'(i));
    issue(1'b0, 1'b0, 4'hF, 32'h300, '0, 8, 8);
    wait_idle("dhit_hold");

    // 6: masked load; operands disturbed and start re-pulsed during ACCESS.
    for (int i = 0; i < 3; i++) begin
      push_mem(1'b0, 32'h400 + 32'(4 * i), '0, 1);
      push_wb(2'(i), 32'hA0 + 32'(i));
    end
    issue(1'b0, 1'b1, 4'b0111, 32'h400, '0, 4, 4);
    bus.mask = 4'b1000;
    for (int i = 0; i < 4; i++) bus.lane_addr[i*32 +: 32] = 32'h600 + 32'(4 * i);
    bus.lane_wdata = '1;
    @(posedge CLK); #1;
    bus.is_store = 1'b1;
    bus.start    = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    wait_idle("restart_ignored");
    repeat (3) @(posedge CLK);

    chk("q_mem_empty", q_mem.size(), 32'd0);
    chk("q_wb_empty", q_wb.size(), 32'd0);
    chk("q_done_empty", q_done.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
